// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequential RAM read sequencer that hides the one-cycle
// read latency and presents the words as a valid/ready stream.
`default_nettype none

module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  RSR_Clk,
    input  logic                  RSR_Reset_n,
    input  logic                  RSR_Start,
    input  logic [ADDR_WIDTH-1:0] RSR_Base_Addr,
    input  logic [ADDR_WIDTH:0]   RSR_Length,
    output logic [ADDR_WIDTH-1:0] RSR_Ram_Address,
    output logic                  RSR_Ram_Oe,
    input  logic [DATA_WIDTH-1:0] RSR_Ram_Data_In,
    input  logic                  RSR_Ready,
    output logic                  RSR_Valid,
    output logic [DATA_WIDTH-1:0] RSR_Data_Out,
    output logic                  RSR_Last,
    output logic                  RSR_Busy,
    output logic                  RSR_Done
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   c_ONE       = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic [ADDR_WIDTH:0]   r_pop_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_fifo_wr;
    logic                  r_fifo_rd;
    logic [1:0]            r_fifo_cnt;
    logic                  r_busy;
    logic                  r_oe;
    logic                  r_done;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_last_pop;
    logic [2:0]            w_pending;
    logic                  w_issue;

    assign w_valid    = (r_fifo_cnt != 2'd0);
    assign w_pop      = w_valid & RSR_Ready;
    assign w_last_pop = w_pop && (r_pop_cnt == r_len - c_ONE);
    // Words already buffered or in the RAM pipe, net of this cycle's pop.
    assign w_pending  = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == S_READ) && (r_issue_cnt < r_len) && (w_pending < 3'd2);

    assign RSR_Ram_Address = r_rd_ptr;
    assign RSR_Ram_Oe      = r_oe;
    assign RSR_Valid       = w_valid;
    assign RSR_Data_Out    = w_valid ? r_fifo_data[r_fifo_rd] : '0;
    assign RSR_Last        = w_valid & r_fifo_last[r_fifo_rd];
    assign RSR_Busy        = r_busy;
    assign RSR_Done        = r_done;

    always_ff @(posedge RSR_Clk or negedge RSR_Reset_n) begin
        if (!RSR_Reset_n) begin
            r_state         <= S_IDLE;
            r_rd_ptr        <= '0;
            r_len           <= '0;
            r_issue_cnt     <= '0;
            r_pop_cnt       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_last     <= 2'b00;
            r_fifo_wr       <= 1'b0;
            r_fifo_rd       <= 1'b0;
            r_fifo_cnt      <= 2'd0;
            r_busy          <= 1'b0;
            r_oe            <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == r_len - c_ONE);

            if (w_issue) begin
                r_rd_ptr    <= (r_rd_ptr == c_LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
                r_issue_cnt <= r_issue_cnt + c_ONE;
            end

            if (r_inflight) begin
                r_fifo_data[r_fifo_wr] <= RSR_Ram_Data_In;
                r_fifo_last[r_fifo_wr] <= r_inflight_last;
                r_fifo_wr              <= ~r_fifo_wr;
            end

            if (w_pop) begin
                r_fifo_rd <= ~r_fifo_rd;
                r_pop_cnt <= r_pop_cnt + c_ONE;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (RSR_Start) begin
                        r_rd_ptr    <= RSR_Base_Addr;
                        r_len       <= RSR_Length;
                        r_issue_cnt <= '0;
                        r_pop_cnt   <= '0;
                        if (RSR_Length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_oe    <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_oe    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench with a registered-read RAM model.
`default_nettype none

module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_oe;
    logic [DW-1:0] ram_q = '0;
    logic          ready = 1'b0;
    logic          valid;
    logic [DW-1:0] dout;
    logic          last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [MS];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .RSR_Clk(clk), .RSR_Reset_n(rst_n), .RSR_Start(start),
        .RSR_Base_Addr(base), .RSR_Length(len),
        .RSR_Ram_Address(ram_addr), .RSR_Ram_Oe(ram_oe), .RSR_Ram_Data_In(ram_q),
        .RSR_Ready(ready), .RSR_Valid(valid), .RSR_Data_Out(dout),
        .RSR_Last(last), .RSR_Busy(busy), .RSR_Done(done)
    );

    // Leaves the caller at the negedge of cycle 1 (Start sampled at edge 0).
    task automatic issue_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
        @(negedge clk);
        base  = b;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({valid, last, busy, done, ram_oe, ram_addr, dout} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v%b l%b b%b d%b oe%b a%0d q%0h, want all zero",
                     valid, last, busy, done, ram_oe, ram_addr, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [11:0] got, exp;
        ready = 1'b1;
        issue_cmd(10'd5, 11'd4);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) @(negedge clk);
            exp[11] = (cyc >= 3 && cyc <= 6);
            exp[10] = (cyc == 6);
            exp[9]  = (cyc >= 1 && cyc <= 6);
            exp[8]  = (cyc == 7);
            exp[7:0] = exp[11] ? 8'(5 + cyc - 3) : 8'h00;
            got = {valid, last, busy, done, dout};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL basic_cycle%0d: got v%b l%b b%b d%b q%0h, want v%b l%b b%b d%b q%0h",
                         cyc, got[11], got[10], got[9], got[8], got[7:0],
                         exp[11], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        logic [DW-1:0] exp_data [4];
        exp_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        exp_data = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ready = 1'b1;
        issue_cmd(10'd1022, 11'd4);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc <= 4) begin
                n_vec++;
                if (ram_addr !== exp_addr[cyc-1] || ram_oe !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap_addr%0d: got %0d oe%b, want %0d oe1",
                             cyc, ram_addr, ram_oe, exp_addr[cyc-1]);
                end
            end
            if (cyc >= 3) begin
                n_vec++;
                if (valid !== 1'b1 || dout !== exp_data[cyc-3] || last !== (cyc == 6)) begin
                    n_err++;
                    $display("FAIL wrap_data%0d: got v%b q%0h l%b, want v1 q%0h l%b",
                             cyc - 3, valid, dout, last, exp_data[cyc-3], cyc == 6);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic          pat [12];
        int            pops, issued, cyc;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        bit            seen_done;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pops = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; seen_done = 0;
        ready = 1'b0;
        issue_cmd(10'd0, 11'd6);
        for (cyc = 1; cyc < 100 && !seen_done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            ready = pat[cyc % 12];
            if (done) seen_done = 1;
            if (prev_stall) begin
                n_vec++;
                if (valid !== 1'b1 || dout !== prev_data || last !== prev_last) begin
                    n_err++;
                    $display("FAIL bp_stable_c%0d: got v%b q%0h l%b, want v1 q%0h l%b",
                             cyc, valid, dout, last, prev_data, prev_last);
                end
            end
            issued = int'(ram_addr);
            if (busy && issued - pops > 2) begin
                n_vec++;
                n_err++;
                $display("FAIL bp_ahead_c%0d: got %0d reads ahead, want <= 2", cyc, issued - pops);
            end
            if (valid && ready) begin
                n_vec++;
                if (dout !== DW'(pops) || last !== (pops == 5)) begin
                    n_err++;
                    $display("FAIL bp_word%0d: got q%0h l%b, want q%0h l%b",
                             pops, dout, last, DW'(pops), pops == 5);
                end
                pops++;
            end
            prev_stall = valid & ~ready;
            prev_data  = dout;
            prev_last  = last;
        end
        n_vec++;
        if (!seen_done || pops != 6) begin
            n_err++;
            $display("FAIL bp_complete: got done=%0d pops=%0d, want done=1 pops=6", seen_done, pops);
        end
        ready = 1'b1;
    endtask

    task automatic test_zero_len();
        issue_cmd(10'd7, 11'd0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_c1: got d%b b%b v%b, want d1 b0 v0", done, busy, valid);
        end
        for (int cyc = 2; cyc <= 4; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len_c%0d: got d%b b%b v%b, want d0 b0 v0", cyc, done, busy, valid);
            end
        end
    endtask

    task automatic test_full_len();
        int  words, errs, cyc;
        bit  started, gap, seen_done;
        words = 0; errs = 0; started = 0; gap = 0; seen_done = 0;
        ready = 1'b1;
        issue_cmd(10'd0, 11'd1024);
        for (cyc = 1; cyc < 1100 && !seen_done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done) seen_done = 1;
            if (valid) begin
                started = 1;
                if (dout !== DW'(words) || last !== (words == 1023)) errs++;
                words++;
            end else if (started && words < 1024) begin
                gap = 1;
            end
        end
        n_vec++;
        if (words != 1024 || errs != 0 || gap || !seen_done) begin
            n_err++;
            $display("FAIL full_len: got words=%0d bad=%0d gap=%0d done=%0d, want 1024 0 0 1",
                     words, errs, gap, seen_done);
        end
    endtask

    task automatic test_reset_midcmd();
        ready = 1'b0;
        issue_cmd(10'd0, 11'd8);
        repeat (5) @(negedge clk);
        n_vec++;
        if (valid !== 1'b1 || busy !== 1'b1 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL rst_pre: got v%b b%b q%0h, want v1 b1 q0", valid, busy, dout);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({valid, busy, ram_oe, done, ram_addr, dout} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got v%b b%b oe%b d%b a%0d q%0h, want all zero",
                     valid, busy, ram_oe, done, ram_addr, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done: got d%b, want d0", done);
        end
        ready = 1'b1;
        issue_cmd(10'd10, 11'd2);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 3 || cyc == 4) begin
                n_vec++;
                if (valid !== 1'b1 || dout !== 8'(7 + cyc) || last !== (cyc == 4)) begin
                    n_err++;
                    $display("FAIL rst_restart_w%0d: got v%b q%0h l%b, want v1 q%0h l%b",
                             cyc - 3, valid, dout, last, 8'(7 + cyc), cyc == 4);
                end
            end
            if (cyc == 5) begin
                n_vec++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL rst_restart_done: got d%b b%b, want d1 b0", done, busy);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = 8'(i & 8'hFF);
        #12;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_len();
        test_reset_midcmd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
